leds_output_sink: RTL and testbench
===================================

# leds_output_sink

Consumer end of the 32-bit stb/ack output stream that user-design processes drive toward the board LEDs. It accepts one word per transfer, latches the low 8 bits as the LED pattern, and drives the physical LED pins. After each accepted word it holds the pattern for a programmable minimum display time, applying back-pressure through ack, so fast producers such as a Knight Rider scanner are paced to a visible rate. It sits at the top level between the `output_leds` stream of `user_design` and the board LED pins.

## Interface
Parameters:
- `HOLD_CYCLES`, 50000: minimum cycles a pattern is displayed before the next word is accepted; 0 = no hold; range 0 to 2^32-1.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  reset, synchronous, active-high.
- `input_leds`  input  32  data word; [7:0] = LED pattern, [15:8] = brightness (PWM build only), [31:16] ignored.
- `input_leds_stb`  input  1  producer strobe; data valid.
- `input_leds_ack`  output  1  consumer acknowledge.
- `leds`  output  8  LED pins, active-high, bit i drives LED i.
- `busy`  output  1  high while in HOLD.

## Operation
- Transfer occurs on a rising edge where `input_leds_stb` and `input_leds_ack` are both high. The producer may present stb at any time and must hold data stable until the transfer.
- `input_leds_ack` = (state == IDLE) and not `rst`. This is combinational from the state register, with no combinational path from stb.
- States:
  - IDLE: ack high. On transfer, latch pattern (and duty), load hold counter with `HOLD_CYCLES`-1, and go to HOLD. If `HOLD_CYCLES` = 0, stay in IDLE; back-to-back transfers are then accepted every cycle.
  - HOLD: ack low, busy high. The counter decrements each cycle. When the counter is 0, return to IDLE on that edge. stb is ignored in HOLD.
- The hold counter is 32 bits, unsigned, and never wraps: the decrement occurs only when the counter is nonzero.
- Only bits [7:0] (and [15:8] with PWM) are used. Upper bits have no effect.
- Reset mid-HOLD: state is forced to IDLE and the pattern is cleared on the same edge. Any pending stb is not accepted on a reset cycle.

## Timing
- Reset values, after any edge with `rst` high: state IDLE, pattern 0x00, duty 0xFF, hold counter 0, PWM counter 0. `leds` = 0x00, `busy` = 0. `input_leds_ack` = 0 while `rst` is high and 1 on the first cycle after it falls.
- Latency: a transfer at edge k updates `leds` at edge k, so the new pattern is visible in cycle k+1 (subject to PWM).
- With `HOLD_CYCLES` = N ≥ 1, ack is low for exactly N cycles (k+1 … k+N). Ack is high again in cycle k+N+1, when the next transfer is possible. Maximum throughput is one word per N+1 cycles.
- `busy` is the exact complement of ack outside reset.

## Configuration
- `LEDS_OUTPUT_SINK_PWM_EN` defined:
  - Bits [15:8] of each accepted word are latched as duty D.
  - An 8-bit free-running counter P increments every cycle and wraps 255→0.
  - `leds[i]` = pattern[i] and (P < D), except D = 0xFF, which forces fully on.
  - D = 0x00 forces all LEDs off.
  - Duty and pattern update on the same edge. P is not reset by transfers.
- `LEDS_OUTPUT_SINK_PWM_EN` undefined:
  - No PWM counter and no duty register. `leds` = pattern directly, and bits [15:8] are ignored.

## Test plan
- Reset then idle: `rst` high 3 cycles → `leds`=0x00, ack=0, busy=0 during reset; ack=1 in the first cycle after.
- Single transfer, `HOLD_CYCLES`=4: present 0x0000FF81 with stb → `leds`=0x81 next cycle; ack low exactly 4 cycles, then high.
- Back-pressure: `HOLD_CYCLES`=4, stb held high with 0x01, then 0x02 offered immediately → 0x02 is accepted only in the 5th cycle after the first transfer; `leds` shows 0x01 for 5 cycles.
- Zero hold: `HOLD_CYCLES`=0, stream 0x01,0x02,0x04,0x08 on consecutive cycles → ack stays high and `leds` follows with 1-cycle latency; busy never rises.
- Reset mid-hold: `HOLD_CYCLES`=10, transfer 0xAA, assert `rst` at hold cycle 3 → `leds`=0x00, state IDLE, ack=1 in the first cycle after `rst` falls.
- PWM (macro defined): word 0x00004001 → `leds[0]` high for 64 of every 256 cycles. Word 0x0000FF01 → `leds[0]` constantly high. Word 0x00000001 → constantly low.

Source files
------------

// File: rtl/leds_output_sink.sv
// leds_output_sink: consumer end of the 32-bit stb/ack LED stream.
// Latches word[7:0] as the LED pattern and holds it for HOLD_CYCLES cycles,
// deasserting ack so fast producers are paced to a visible rate.
// Optional feature: define LEDS_OUTPUT_SINK_PWM_EN to latch word[15:8] as a
// brightness duty and gate the LEDs with a free-running 8-bit PWM counter.
module leds_output_sink #(
    parameter int unsigned HOLD_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_leds,
    input  logic        input_leds_stb,
    output logic        input_leds_ack,
    output logic [7:0]  leds,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES) - 32'd1;
    localparam bit          HOLD_EN   = (HOLD_CYCLES != 0);

    state_t      state_q, state_d;
    logic [7:0]  pattern_q, pattern_d;
    logic [31:0] cnt_q, cnt_d;
    logic        xfer;

    // ack depends only on the state register and reset, never on stb
    assign input_leds_ack = (state_q == IDLE) && !rst;
    assign busy           = (state_q == HOLD);
    assign xfer           = input_leds_stb && input_leds_ack;

    // State, pattern and hold counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= 8'h00;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: accept a word in IDLE, count the hold time down in HOLD
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    pattern_d = input_leds[7:0];
                    if (HOLD_EN) begin
                        cnt_d   = HOLD_LOAD;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // counter saturates at zero; zero ends the hold on this edge
                if (cnt_q == 32'd0) state_d = IDLE;
                else                cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LEDS_OUTPUT_SINK_PWM_EN
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_q;

    // Duty register loads alongside the pattern
    always_comb begin
        duty_d = duty_q;
        if (state_q == IDLE && xfer) duty_d = input_leds[15:8];
    end

    // Duty and free-running PWM counter; transfers never reset the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= 8'hFF;
            pwm_q  <= 8'h00;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_q + 8'd1;
        end
    end

    // 0xFF means fully on; otherwise on while the counter is below the duty
    always_comb begin
        if (duty_q == 8'hFF || pwm_q < duty_q) leds = pattern_q;
        else                                   leds = 8'h00;
    end

    logic unused_hi;
    assign unused_hi = ^input_leds[31:16];
`else
    assign leds = pattern_q;

    logic unused_hi;
    assign unused_hi = ^input_leds[31:8];
`endif

endmodule

// File: tb/tb_leds_output_sink.sv
// Self-checking bench for leds_output_sink: three instances with hold
// lengths 4, 0 and 10 share clock and reset; expected LED patterns are
// queued when words are driven and popped when the DUT shows them.
module tb_leds_output_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] d4 = '0, d0 = '0, d10 = '0;
    logic        stb4 = 1'b0, stb0 = 1'b0, stb10 = 1'b0;
    logic        ack4, ack0, ack10;
    logic        busy4, busy0, busy10;
    logic [7:0]  leds4, leds0, leds10;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];
    logic [7:0]  exp_v;

    always #5 clk = ~clk;

    leds_output_sink #(.HOLD_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .input_leds(d4), .input_leds_stb(stb4),
        .input_leds_ack(ack4), .leds(leds4), .busy(busy4));

    leds_output_sink #(.HOLD_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .input_leds(d0), .input_leds_stb(stb0),
        .input_leds_ack(ack0), .leds(leds0), .busy(busy0));

    leds_output_sink #(.HOLD_CYCLES(10)) u10 (
        .clk(clk), .rst(rst), .input_leds(d10), .input_leds_stb(stb10),
        .input_leds_ack(ack10), .leds(leds10), .busy(busy10));

    // rst high for 3 cycles, then ack must rise in the following cycle
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({leds4, leds0, leds10} !== 24'h0 || {ack4, ack0, ack10} !== 3'b000 ||
                {busy4, busy0, busy10} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_state: leds=%h/%h/%h ack=%b%b%b busy=%b%b%b want leds=0 ack=0 busy=0",
                         leds4, leds0, leds10, ack4, ack0, ack10, busy4, busy0, busy10);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ack4, ack0, ack10} !== 3'b111 || {busy4, busy0, busy10} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: ack=%b%b%b busy=%b%b%b want ack=111 busy=000",
                     ack4, ack0, ack10, busy4, busy0, busy10);
        end
    endtask

    // Wait (bounded) for the hold-4 instance to return to IDLE
    task automatic wait_idle4();
        for (int i = 0; i < 20 && ack4 !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (ack4 !== 1'b1) begin
            n_err++;
            $display("FAIL idle_wait: ack=%b want 1", ack4);
        end
    endtask

    // One word, hold of 4: pattern next cycle, ack low exactly 4 cycles
    task automatic test_single();
        d4 = 32'h0000FF81; stb4 = 1'b1; sb.push_back(8'h81);
        @(negedge clk);
        stb4 = 1'b0;
        exp_v = sb.pop_front();
        n_cmp++;
        if (leds4 !== exp_v) begin
            n_err++;
            $display("FAIL single_leds: got %h want %h", leds4, exp_v);
        end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (ack4 !== 1'b0 || busy4 !== 1'b1) begin
                n_err++;
                $display("FAIL single_hold_c%0d: ack=%b busy=%b want ack=0 busy=1", i, ack4, busy4);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ack4 !== 1'b1 || busy4 !== 1'b0 || leds4 !== 8'h81) begin
            n_err++;
            $display("FAIL single_release: ack=%b busy=%b leds=%h want ack=1 busy=0 leds=81",
                     ack4, busy4, leds4);
        end
    endtask

    // stb held high: second word waits out the hold, accepted in 5th cycle
    task automatic test_back_to_back();
        d4 = 32'h0000FF01; stb4 = 1'b1; sb.push_back(8'h01); sb.push_back(8'h02);
        @(negedge clk);
        d4 = 32'h0000FF02;
        exp_v = sb.pop_front();
        for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if (leds4 !== exp_v || ack4 !== (i == 5)) begin
                n_err++;
                $display("FAIL bp_cycle%0d: leds=%h ack=%b want leds=%h ack=%b",
                         i, leds4, ack4, exp_v, (i == 5));
            end
            @(negedge clk);
        end
        stb4 = 1'b0;
        exp_v = sb.pop_front();
        n_cmp++;
        if (leds4 !== exp_v || busy4 !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: leds=%h busy=%b want leds=%h busy=1", leds4, busy4, exp_v);
        end
        wait_idle4();
    endtask

    // Hold 0: a new word every cycle, ack never drops
    task automatic test_zero_hold();
        logic [31:0] words [4];
`ifdef LEDS_OUTPUT_SINK_PWM_EN
        words = '{32'h0000FF01, 32'hABCDFF02, 32'h0000FF04, 32'h1234FF08};
`else
        words = '{32'h00000001, 32'hABCD0002, 32'h0000FF04, 32'h12345608};
`endif
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                exp_v = sb.pop_front();
                n_cmp++;
                if (leds0 !== exp_v || ack0 !== 1'b1 || busy0 !== 1'b0) begin
                    n_err++;
                    $display("FAIL zero_hold_w%0d: leds=%h ack=%b busy=%b want leds=%h ack=1 busy=0",
                             i, leds0, ack0, busy0, exp_v);
                end
            end
            if (i < 4) begin
                d0 = words[i]; stb0 = 1'b1;
                sb.push_back(8'h01 << i);
            end else begin
                stb0 = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (leds0 !== 8'h08 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL zero_hold_idle: leds=%h busy=%b want leds=08 busy=0", leds0, busy0);
        end
    endtask

    // Reset during hold cycle 3; a pending stb must not be taken on reset
    task automatic test_reset_mid_hold();
        d10 = 32'h0000FFAA; stb10 = 1'b1; sb.push_back(8'hAA);
        @(negedge clk);
        stb10 = 1'b0;
        exp_v = sb.pop_front();
        n_cmp++;
        if (leds10 !== exp_v || busy10 !== 1'b1) begin
            n_err++;
            $display("FAIL rmh_latch: leds=%h busy=%b want leds=%h busy=1", leds10, busy10, exp_v);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; d10 = 32'h0000FF55; stb10 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (leds10 !== 8'h00 || ack10 !== 1'b0 || busy10 !== 1'b0) begin
            n_err++;
            $display("FAIL rmh_in_reset: leds=%h ack=%b busy=%b want leds=00 ack=0 busy=0",
                     leds10, ack10, busy10);
        end
        rst = 1'b0; stb10 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (leds10 !== 8'h00 || ack10 !== 1'b1 || busy10 !== 1'b0) begin
            n_err++;
            $display("FAIL rmh_after: leds=%h ack=%b busy=%b want leds=00 ack=1 busy=0",
                     leds10, ack10, busy10);
        end
    endtask

`ifdef LEDS_OUTPUT_SINK_PWM_EN
    // Duty 0x40 -> 64/256 on, 0xFF -> always on, 0x00 -> always off
    task automatic test_pwm();
        logic [31:0] w [3];
        int          want [3];
        int          on;
        w = '{32'h00004001, 32'h0000FF01, 32'h00000001};
        want = '{64, 256, 0};
        for (int t = 0; t < 3; t++) begin
            wait_idle4();
            d4 = w[t]; stb4 = 1'b1;
            @(negedge clk);
            stb4 = 1'b0;
            on = 0;
            for (int c = 0; c < 256; c++) begin
                if (leds4[0] === 1'b1) on++;
                @(negedge clk);
            end
            n_cmp++;
            if (on != want[t]) begin
                n_err++;
                $display("FAIL pwm_duty%0d: on_cycles=%0d want %0d", t, on, want[t]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_hold();
        test_reset_mid_hold();
`ifdef LEDS_OUTPUT_SINK_PWM_EN
        test_pwm();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
